// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : Drives a bank of WIDTH JK flip-flop cells toward a requested
//            target word. A request is accepted over valid/ready. The block
//            computes per-lane J/K excitation from the bank's live Q
//            feedback and pulses the bank clock enable for one cycle. It then
//            checks the result and retries until the bank matches or the
//            retry budget runs out.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      number of JK lanes driven
//   MAX_RETRY  extra drive attempts after the first before reporting an error
// Ports
//   iClk     in   1      clock (rising edge)
//   iRst     in   1      synchronous active-high reset
//   iValid   in   1      target request valid
//   oReady   out  1      block can accept a request (IDLE only)
//   iTarget  in   WIDTH  requested Q value
//   iMode    in   1      0 = force (set/reset), 1 = toggle excitation
//   iQ       in   WIDTH  registered Q feedback from the JK bank
//   oJ       out  WIDTH  J drive to the bank
//   oK       out  WIDTH  K drive to the bank
//   oCE      out  1      clock enable to the bank
//   oBusy    out  1      request in progress (DRIVE or CHECK)
//   oDone    out  1      one-cycle pulse: bank matches target
//   oErr     out  1      one-cycle pulse: retries exhausted
// ============================================================================
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iTarget,
  input  logic             iMode,
  input  logic [WIDTH-1:0] iQ,
  output logic [WIDTH-1:0] oJ,
  output logic [WIDTH-1:0] oK,
  output logic             oCE,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr
);

  // The counter only has to reach MAX_RETRY; keep it at least one bit wide.
  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] retry_cnt;
  logic [WIDTH-1:0] target_q;
  logic             mode_q;

  logic [WIDTH-1:0] diff;
  logic             accept;
  logic             match;
  logic             retry_left;

  assign diff       = iQ ^ target_q;
  assign match      = (iQ == target_q);
  assign retry_left = (retry_cnt != RETRY_LIMIT);
  assign accept     = (state == S_IDLE) && iValid;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= S_IDLE;
      retry_cnt <= '0;
      target_q  <= '0;
      mode_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        target_q  <= iTarget;
        mode_q    <= iMode;
        retry_cnt <= '0;
      end else if ((state == S_CHECK) && !match && retry_left) begin
        // Increment only when another attempt will follow, so the counter
        // never wraps past RETRY_LIMIT.
        retry_cnt <= retry_cnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. Excitation is driven from live iQ during
  // DRIVE so every attempt reacts to the bank's actual contents; lanes that
  // already match get J = K = 0 because their diff bit is zero.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    oReady    = 1'b0;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    oErr      = 1'b0;
    oJ        = '0;
    oK        = '0;
    oCE       = 1'b0;

    case (state)
      S_IDLE: begin
        oReady = 1'b1;
        if (iValid) state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        oBusy = 1'b1;
        if (mode_q) begin
          oJ = diff;
          oK = diff;
        end else begin
          oJ = target_q & diff;
          oK = ~target_q & diff;
        end
        oCE       = |diff;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        oBusy = 1'b1;
        if (match)           state_nxt = S_DONE;
        else if (!retry_left) state_nxt = S_ERR;
        else                 state_nxt = S_DRIVE;
      end
      S_DONE: begin
        oDone     = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        oErr      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_driver
// Purpose  : Self-checking bench for jk_bank_driver with a behavioural JK
//            bank (WIDTH = 4, MAX_RETRY = 3). Expected outcomes are queued
//            when a request is issued and compared when the DUT reports.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_bank_driver;

  localparam int WIDTH     = 4;
  localparam int MAX_RETRY = 3;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iTarget;
  logic             iMode;
  logic [WIDTH-1:0] iQ;
  logic [WIDTH-1:0] oJ;
  logic [WIDTH-1:0] oK;
  logic             oCE;
  logic             oBusy;
  logic             oDone;
  logic             oErr;

  // Behavioural JK bank: external load path plus stuck-at-0 lane mask.
  logic [WIDTH-1:0] bank = '0;
  logic [WIDTH-1:0] stuck_mask = '0;
  logic             load_en = 1'b0;
  logic [WIDTH-1:0] load_val = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    int         lat;
    int         n_ce;
    logic [3:0] j;
    logic [3:0] k;
  } exp_t;

  exp_t sb[$];

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iTarget(iTarget),
    .iMode  (iMode),
    .iQ     (iQ),
    .oJ     (oJ),
    .oK     (oK),
    .oCE    (oCE),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oErr   (oErr)
  );

  always #5 iClk = ~iClk;

  assign iQ = bank & ~stuck_mask;

  // JK semantics per lane: 10 set, 01 reset, 11 toggle, 00 hold.
  always @(posedge iClk) begin
    if (load_en)
      bank <= load_val;
    else if (oCE)
      bank <= (oJ & ~oK) | (~oJ & ~oK & iQ) | (oJ & oK & ~iQ);
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_bank(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    tick();
    load_en  = 1'b0;
  endtask

  // Present a request while IDLE, push its expected outcome, and step past
  // the accepting edge so the caller lands in the first DRIVE cycle.
  task automatic send(input logic [3:0] tgt, input logic md, input exp_t e);
    iTarget = tgt;
    iMode   = md;
    iValid  = 1'b1;
    chk("ready_before_accept", 32'(oReady), 32'd1);
    sb.push_back(e);
    tick();
    iValid  = 1'b0;
    iTarget = 4'h0;
    iMode   = 1'b0;
  endtask

  // Called in cycle 1 after the accepting edge. Counts CE cycles, checks
  // their excitation, and measures the cycle of the completion pulse.
  task automatic wait_result(input string tag);
    exp_t e;
    int   cyc;
    int   n_ce;
    e    = sb.pop_front();
    cyc  = 1;
    n_ce = 0;
    forever begin
      if (oCE) begin
        n_ce++;
        chk({tag, "_drive_j"}, 32'(oJ), 32'(e.j));
        chk({tag, "_drive_k"}, 32'(oK), 32'(e.k));
      end
      if (oDone || oErr || cyc >= e.lat + 6) break;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_done"}, 32'(oDone), 32'(!e.is_err));
    chk({tag, "_err"}, 32'(oErr), 32'(e.is_err));
    chk({tag, "_ce_count"}, 32'(n_ce), 32'(e.n_ce));
    tick();
    chk({tag, "_ready_after"}, 32'(oReady), 32'd1);
    chk({tag, "_pulse_low"}, 32'({oDone, oErr}), 32'd0);
  endtask

  initial begin
    iRst    = 1'b1;
    iValid  = 1'b1;
    iTarget = 4'hF;
    iMode   = 1'b0;

    // Reset held two cycles with a pending request that must be dropped.
    tick();
    tick();
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_busy",  32'(oBusy),  32'd0);
    chk("rst_done",  32'(oDone),  32'd0);
    chk("rst_err",   32'(oErr),   32'd0);
    chk("rst_j",     32'(oJ),     32'd0);
    chk("rst_k",     32'(oK),     32'd0);
    chk("rst_ce",    32'(oCE),    32'd0);
    iRst   = 1'b0;
    iValid = 1'b0;
    tick();
    chk("post_rst_idle_ready", 32'(oReady), 32'd1);
    chk("post_rst_idle_busy",  32'(oBusy),  32'd0);

    // Force mode: 0000 -> 1010.
    load_bank(4'b0000);
    send(4'b1010, 1'b0, '{is_err: 1'b0, lat: 3, n_ce: 1, j: 4'b1010, k: 4'b0000});
    chk("force_drive_ce",    32'(oCE),    32'd1);
    chk("force_drive_busy",  32'(oBusy),  32'd1);
    chk("force_drive_ready", 32'(oReady), 32'd0);
    wait_result("force");
    chk("force_bank", 32'(iQ), 32'b1010);

    // Toggle mode: 0110 -> 0011.
    load_bank(4'b0110);
    send(4'b0011, 1'b1, '{is_err: 1'b0, lat: 3, n_ce: 1, j: 4'b0101, k: 4'b0101});
    chk("toggle_drive_ce", 32'(oCE), 32'd1);
    wait_result("toggle");
    chk("toggle_bank", 32'(iQ), 32'b0011);

    // No-op: bank already holds the target.
    load_bank(4'b1100);
    send(4'b1100, 1'b0, '{is_err: 1'b0, lat: 3, n_ce: 0, j: 4'b0000, k: 4'b0000});
    chk("noop_drive_j",  32'(oJ),  32'd0);
    chk("noop_drive_k",  32'(oK),  32'd0);
    chk("noop_drive_ce", 32'(oCE), 32'd0);
    wait_result("noop");

    // Stuck lane 0: four attempts then an error pulse in cycle 9.
    stuck_mask = 4'b0001;
    load_bank(4'b0000);
    send(4'b0001, 1'b0, '{is_err: 1'b1, lat: 9, n_ce: 4, j: 4'b0001, k: 4'b0000});
    wait_result("stuck");

    // Reset during the CHECK of the first retry (cycle 4 after accept).
    iTarget = 4'b0001;
    iMode   = 1'b0;
    iValid  = 1'b1;
    tick();
    iValid  = 1'b0;
    tick();                       // cycle 2: CHECK
    tick();                       // cycle 3: DRIVE (retry 1)
    tick();                       // cycle 4: CHECK (retry 1)
    chk("midrst_in_check_busy", 32'(oBusy), 32'd1);
    chk("midrst_in_check_ce",   32'(oCE),   32'd0);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("midrst_ready", 32'(oReady), 32'd1);
    chk("midrst_busy",  32'(oBusy),  32'd0);
    tick();
    send(4'b0001, 1'b0, '{is_err: 1'b1, lat: 9, n_ce: 4, j: 4'b0001, k: 4'b0000});
    wait_result("after_rst");

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
